// File: rtl/rst_seq_pkg.sv
// Shared types and configuration checks for the staged reset/enable sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'b00,
        ST_REL   = 2'b01,
        ST_RUN   = 2'b10,
        ST_DRAIN = 2'b11
    } state_e;

    function automatic bit cfg_ok(input int n, input int hold, input int dly, input int cntw);
        if (n < 1 || n > 8)          return 1'b0;
        if (hold < 1 || dly < 1)     return 1'b0;
        if (cntw < 1 || cntw > 31)   return 1'b0;
        if ((longint'(1) << cntw) <= longint'(hold)) return 1'b0;
        if ((longint'(1) << cntw) <= longint'(dly))  return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/rst_seq_cnt.sv
// Phase counter shared by the hold and stage-delay phases; self-clears on reaching the terminal value.
module rst_seq_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] term_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign done_o = inc_i && (cnt_q == term_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || done_o) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rst_seq.sv
// Staged reset/enable sequencer: releases N_STAGE domains in order and replays on soft-reset request.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int unsigned N_STAGE   = 4,
    parameter int unsigned HOLD_CYC  = 16,
    parameter int unsigned STAGE_DLY = 8,
    parameter int unsigned CNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               soft_req,
    output logic               soft_ack,
    output logic [N_STAGE-1:0] stage_rst,
    output logic [N_STAGE-1:0] stage_en,
    output logic               ready,
    output logic [2:0]         stage_idx
);

    if (!cfg_ok(N_STAGE, HOLD_CYC, STAGE_DLY, CNT_W)) begin : g_bad_cfg
        $error("rst_seq: parameter set out of range");
    end

    localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] DLY_TERM  = CNT_W'(STAGE_DLY - 1);
    localparam logic [2:0]       LAST_IDX  = 3'(N_STAGE - 1);

    state_e             state_q, state_d;
    logic [N_STAGE-1:0] srst_q, srst_d;
    logic [N_STAGE-1:0] en_q, en_d;
    logic               ready_q, ready_d;
    logic               ack_q, ack_d;
    logic [2:0]         idx_q, idx_d;

    logic               cnt_clr, cnt_inc, cnt_done;
    logic [CNT_W-1:0]   cnt_term;

    rst_seq_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .term_i (cnt_term),
        .done_o (cnt_done)
    );

    always_comb begin
        state_d  = state_q;
        srst_d   = srst_q;
        en_d     = en_q;
        ready_d  = ready_q;
        ack_d    = 1'b0;
        idx_d    = idx_q;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        cnt_term = HOLD_TERM;

        unique case (state_q)
            ST_HOLD: begin
                cnt_inc = 1'b1;
                if (cnt_done) begin
                    state_d   = ST_REL;
                    srst_d[0] = 1'b0;
                end
            end
            ST_REL: begin
                cnt_inc  = 1'b1;
                cnt_term = DLY_TERM;
                if (cnt_done) begin
                    // Enable the current stage and release the next one on the same edge.
                    for (int unsigned k = 0; k < N_STAGE; k++) begin
                        if (k == 32'(idx_q))        en_d[k]   = 1'b1;
                        if (k == 32'(idx_q) + 1)    srst_d[k] = 1'b0;
                    end
                    idx_d = idx_q + 3'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_RUN;
                        ready_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                cnt_clr = 1'b1;
                if (soft_req) begin
                    state_d = ST_DRAIN;
                    en_d    = '0;
                    ready_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                cnt_clr = 1'b1;
                state_d = ST_HOLD;
                srst_d  = '1;
                ack_d   = 1'b1;
                idx_d   = '0;
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_HOLD;
            srst_q  <= '1;
            en_q    <= '0;
            ready_q <= 1'b0;
            ack_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            srst_q  <= srst_d;
            en_q    <= en_d;
            ready_q <= ready_d;
            ack_q   <= ack_d;
            idx_q   <= idx_d;
        end
    end

    assign stage_rst = srst_q;
    assign stage_en  = en_q;
    assign ready     = ready_q;
    assign soft_ack  = ack_q;
    assign stage_idx = idx_q;

endmodule
